info_navigator: RTL

INFO_NAVIGATOR -- requirements
Module: info_navigator

---
 rtl/info_navigator_pkg.sv | 32 +++
 rtl/info_navigator_edge_sync.sv | 29 ++
 rtl/info_navigator.sv | 111 +++++++++++
 3 files changed

// File: rtl/info_navigator_pkg.sv
// rtl/info_navigator_pkg.sv - select/state enums and bank depth constants for info_navigator
package info_navigator_pkg;

  typedef enum logic [1:0] {
    SEL_INSTR = 2'd0,
    SEL_REG   = 2'd1,
    SEL_HILO  = 2'd2,
    SEL_MEM   = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int DEPTH_INSTR = 256;
  localparam int DEPTH_REG   = 32;
  localparam int DEPTH_HILO  = 2;
  localparam int DEPTH_MEM   = 1024;

  // Highest legal index of a bank, i.e. depth-1.
  function automatic logic [9:0] last_index(input sel_e sel);
    case (sel)
      SEL_INSTR: last_index = 10'(DEPTH_INSTR - 1);
      SEL_REG:   last_index = 10'(DEPTH_REG - 1);
      SEL_HILO:  last_index = 10'(DEPTH_HILO - 1);
      default:   last_index = 10'(DEPTH_MEM - 1);
    endcase
  endfunction

endpackage

// File: rtl/info_navigator_edge_sync.sv
// rtl/info_navigator_edge_sync.sv - edge_sync: button synchronizer followed by a one-cycle rising-edge pulse
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      last_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/info_navigator.sv
// rtl/info_navigator.sv - button-driven bank/index navigator with latched display word; auto-scan under INFO_NAVIGATOR_AUTOSCAN_EN
module info_navigator
  import info_navigator_pkg::*;
#(
  parameter int SCAN_DIV    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btnNext,
  input  logic        btnPrev,
  input  logic        btnMode,
  input  logic        autoScan,
  input  logic [31:0] word,
  output logic [1:0]  select,
  output logic [9:0]  derreference,
  output logic [31:0] shownWord,
  output logic        shownValid
);

  state_e      state_q, state_d;
  sel_e        sel_q, sel_d;
  logic [9:0]  idx_q, idx_d;
  logic        ev_next, ev_prev, ev_mode, tick;
  logic        move;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_next (.clock(clock), .reset(reset), .raw(btnNext), .pulse(ev_next));
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_prev (.clock(clock), .reset(reset), .raw(btnPrev), .pulse(ev_prev));
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mode (.clock(clock), .reset(reset), .raw(btnMode), .pulse(ev_mode));

`ifdef INFO_NAVIGATOR_AUTOSCAN_EN
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic          btn_event;

  assign btn_event = ev_next | ev_prev | ev_mode;
  assign tick      = autoScan && (state_q == ST_IDLE) && (presc_q == PW'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || !autoScan || btn_event) begin
      presc_q <= '0;
    end else if (state_q == ST_IDLE) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end
`else
  logic unused_autoscan;

  assign tick            = 1'b0;
  assign unused_autoscan = autoScan;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    move    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous next/prev pair cancels and also swallows the auto tick.
        if (ev_mode) begin
          sel_d = sel_e'(sel_q + 2'd1);
          idx_d = '0;
          move  = 1'b1;
        end else if (ev_next ^ ev_prev) begin
          if (ev_next) begin
            idx_d = (idx_q == last_index(sel_q)) ? '0 : idx_q + 10'd1;
          end else begin
            idx_d = (idx_q == '0) ? last_index(sel_q) : idx_q - 10'd1;
          end
          move = 1'b1;
        end else if (tick && !ev_next && !ev_prev) begin
          idx_d = (idx_q == last_index(sel_q)) ? '0 : idx_q + 10'd1;
          move  = 1'b1;
        end
        if (move) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_SETTLE;
      sel_q      <= SEL_INSTR;
      idx_q      <= '0;
      shownWord  <= '0;
      shownValid <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      if (move) begin
        shownValid <= 1'b0;
      end
      if (state_q == ST_CAPTURE) begin
        shownWord  <= word;
        shownValid <= 1'b1;
      end
    end
  end

  assign select       = sel_q;
  assign derreference = idx_q;

endmodule
